// File: rtl/demux4way16_sched.sv
// demux4way16_sched
// Routes each accepted word to one of four destinations through a 2-entry
// FIFO of {data, dest}. The FIFO head is presented on the selected output
// with a valid/ready handshake. A head that waits TIMEOUT cycles on a stalled
// destination is dropped and counted in a saturating 8-bit drop counter.
// Outputs are registered. They are loaded from the next-state FIFO head, so a
// new head appears one cycle after its push and follows a pop with no bubble.

module demux4way16_sched #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       drop_count,
    output logic             busy
);

    // The wait counter needs to reach TIMEOUT-1. It is one bit wide when the timeout is disabled.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value at which the next stalled edge completes TIMEOUT presented cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0]  mem_data [2];
    logic [1:0]        mem_dest [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    // Scheduler state
    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        drop_cnt;

    // Registered output image
    logic [3:0]        valid_q;
    logic [WIDTH-1:0]  data_q [4];

    // Combinational decisions for the coming edge
    logic [WIDTH-1:0]  head_data;
    logic [1:0]        head_dest;
    logic              push;
    logic              deliver;
    logic              timeout_hit;
    logic              pop;
    logic [1:0]        count_nxt;
    logic              rd_ptr_nxt;
    logic [WIDTH-1:0]  nxt_data;
    logic [1:0]        nxt_dest;
    logic [3:0]        valid_nxt;
    logic [WIDTH-1:0]  data_nxt [4];

    // Only the registered count gates acceptance. A pop in the same cycle
    // does not open a slot for a push.
    assign in_ready  = (count < 2'd2);
    assign busy      = (count != 2'd0);
    assign head_data = mem_data[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign push      = in_valid && in_ready;

    // Delivery looks only at the ready bit of the head's destination.
    assign deliver     = (state == DRIVE) && out_ready[head_dest];
    assign timeout_hit = (TIMEOUT != 0) && (state == DRIVE) && !deliver
                         && (wait_cnt == WAIT_LAST);
    assign pop         = deliver || timeout_hit;
    assign rd_ptr_nxt  = pop ? ~rd_ptr : rd_ptr;

    // Next occupancy from the push/pop pair
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Next head entry. If the slot the head will occupy is being written on this edge, take the incoming word.
    always_comb begin
        nxt_data = mem_data[rd_ptr_nxt];
        nxt_dest = mem_dest[rd_ptr_nxt];
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            nxt_data = in_data;
            nxt_dest = in_dest;
        end
    end

    // Next output image: only the head's destination is driven; all others are zero
    always_comb begin
        valid_nxt = 4'b0000;
        for (int k = 0; k < 4; k++) data_nxt[k] = '0;
        if (count_nxt != 2'd0) begin
            valid_nxt          = 4'b0001 << nxt_dest;
            data_nxt[nxt_dest] = nxt_data;
        end
    end

    // FIFO storage write on an accepted push
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The cleared count and pointers make stale entries unreachable.
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_dest[wr_ptr] <= in_dest;
        end
    end

    // Scheduler FSM: pointers, occupancy, wait/drop counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            wait_cnt <= '0;
            drop_cnt <= 8'd0;
            valid_q  <= 4'b0000;
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            count   <= count_nxt;
            rd_ptr  <= rd_ptr_nxt;
            valid_q <= valid_nxt;
            for (int k = 0; k < 4; k++) data_q[k] <= data_nxt[k];

            if (push) wr_ptr <= ~wr_ptr;

            state <= (count_nxt != 2'd0) ? DRIVE : IDLE;

            // The wait counter restarts with each new head and counts stalled cycles
            if (pop) begin
                wait_cnt <= '0;
            end else if ((state == DRIVE) && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (timeout_hit && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out0       = data_q[0];
    assign out1       = data_q[1];
    assign out2       = data_q[2];
    assign out3       = data_q[3];
    assign drop_count = drop_cnt;

endmodule

// File: tb/tb_demux4way16_sched.sv
// Testbench for demux4way16_sched.
// The driver records each accepted word into an expected-order queue. The
// monitor compares the DUT outputs once per cycle against that queue. The
// queue holds the words in arrival order. The head leaves on delivery or
// after TO cycles on display, and each drop bumps a saturating counter.

module tb_demux4way16_sched;

    localparam int W  = 16;
    localparam int TO = 15;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   dest;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic [1:0]   in_dest;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0, out1, out2, out3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   drop_count;
    logic         busy;

    item_t        exp_q[$];
    int           exp_drop = 0;
    int           n_checks = 0;
    int           n_fail   = 0;

    demux4way16_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record an accepted word for the edge that closes the current cycle
    task automatic record();
        @(negedge clk);
        #1;
        if (rst_n && in_valid && in_ready) exp_q.push_back('{data: in_data, dest: in_dest});
    endtask

    // One cycle of stimulus: drive just after the edge, then record acceptance
    task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] dst,
                        input logic [3:0] rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        out_ready = rdy;
        record();
    endtask

    // Idle until the model queue empties, within a bounded number of cycles
    task automatic drain(input logic [3:0] rdy, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, '0, 2'd0, rdy);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare the current outputs with the model, then retire the head if it leaves at the coming edge
    initial begin : monitor
        int           wait_cycles;
        logic [3:0]   ev;
        logic [W-1:0] outs [4];
        wait_cycles = 0;
        forever begin
            @(negedge clk);
            outs[0] = out0;
            outs[1] = out1;
            outs[2] = out2;
            outs[3] = out3;
            ev = (exp_q.size() != 0) ? (4'b0001 << exp_q[0].dest) : 4'b0000;
            check("out_valid", 64'(out_valid), 64'(ev));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out%0d", k), 64'(outs[k]),
                      (exp_q.size() != 0 && exp_q[0].dest == 2'(k)) ? 64'(exp_q[0].data) : 64'd0);
            end
            check("in_ready", 64'(in_ready), (exp_q.size() < 2) ? 64'd1 : 64'd0);
            check("busy", 64'(busy), (exp_q.size() != 0) ? 64'd1 : 64'd0);
            check("drop_count", 64'(drop_count), 64'(exp_drop));
            if (!rst_n) begin
                wait_cycles = 0;
            end else if (exp_q.size() != 0) begin
                if (out_ready[exp_q[0].dest]) begin
                    void'(exp_q.pop_front());
                    wait_cycles = 0;
                end else begin
                    wait_cycles++;
                    if (TO > 0 && wait_cycles == TO) begin
                        void'(exp_q.pop_front());
                        if (exp_drop < 255) exp_drop++;
                        wait_cycles = 0;
                    end
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic
    initial begin : driver
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = 2'd0;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);

        // Single word: the first push is accepted at the first edge after release
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        in_dest   = 2'd2;
        out_ready = 4'b0100;
        record();
        repeat (3) step(1'b0, '0, 2'd0, 4'b0100);

        // Back-to-back to different destinations with all ready
        step(1'b1, 16'h0001, 2'd0, 4'b1111);
        step(1'b1, 16'h0002, 2'd3, 4'b1111);
        repeat (3) step(1'b0, '0, 2'd0, 4'b1111);

        // Full: the third word is refused and the first word stays displayed
        step(1'b1, 16'h00A1, 2'd1, 4'b0000);
        step(1'b1, 16'h00A2, 2'd2, 4'b0000);
        step(1'b1, 16'h00A3, 2'd3, 4'b0000);
        repeat (4) step(1'b0, '0, 2'd0, 4'b0000);
        drain(4'b1111, 20);

        // Wrong-ready: bits of non-selected destinations are ignored
        step(1'b1, 16'h1234, 2'd1, 4'b1101);
        repeat (6) step(1'b0, '0, 2'd0, 4'b1101);
        step(1'b0, '0, 2'd0, 4'b0010);
        drain(4'b1111, 20);

        // Randomized traffic with periodic stalls long enough to force drops
        for (int i = 0; i < 900; i++) begin
            logic [3:0] rdy;
            rdy = ((i % 150) >= 110) ? 4'b0000 : 4'($urandom);
            step($urandom_range(0, 3) != 0, W'($urandom), 2'($urandom), rdy);
        end
        drain(4'b1111, 50);

        // Timeout: destination 1 never ready, enough drops to saturate the counter
        for (int i = 0; i < 300 * TO + 10; i++) step(1'b1, W'($urandom), 2'd1, 4'b0000);
        drain(4'b0000, 100);
        check("drop_saturated", 64'(drop_count), 64'd255);

        // Reset mid-operation with two words buffered
        step(1'b1, 16'h5A5A, 2'd0, 4'b0000);
        step(1'b1, 16'hA5A5, 2'd3, 4'b0000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outs", 64'({out0, out1, out2, out3}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After release nothing appears until a new push
        repeat (20) step(1'b0, '0, 2'd0, 4'b1111);
        step(1'b1, 16'hC0DE, 2'd3, 4'b1111);
        drain(4'b1111, 20);
        repeat (2) step(1'b0, '0, 2'd0, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux4way16_sched.md
DEMUX4WAY16_SCHED -- requirements
Module: demux4way16_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles a word waits on a stalled destination before drop; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  word to route.
REQ-006 SHALL have port in_dest  input  2  destination index 0..3.
REQ-007 SHALL have port in_valid  input  1  source offers word.
REQ-008 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-009 SHALL have ports out0, out1, out2, out3  output  WIDTH each  per-destination data.
REQ-010 SHALL have port out_valid  output  4  bit k qualifies outk.
REQ-011 SHALL have port out_ready  input  4  bit k: destination k accepts.
REQ-012 SHALL have port drop_count  output  8  count of timed-out words.
REQ-013 SHALL have port busy  output  1  high when buffer non-empty.

Function
REQ-014 SHALL buffer words in a 2-entry FIFO of {in_data, in_dest}; push when in_valid and in_ready both high at a clock edge.
REQ-015 SHALL drive in_ready = (FIFO count < 2), combinationally from registered count; no push when full, even if a pop occurs in the same cycle.
REQ-016 SHALL implement states IDLE and DRIVE; IDLE when FIFO empty, DRIVE when non-empty.
REQ-017 In DRIVE, SHALL assert only out_valid[d], where d is head entry destination, and drive outd with head data; all other outk SHALL be 0 and their out_valid bits 0.
REQ-018 In IDLE, SHALL drive out_valid = 4'b0000 and all outk = 0.
REQ-019 Handshake: word delivered at an edge where out_valid[d] and out_ready[d] both high; head popped at that edge; next entry presented the following cycle with no bubble.
REQ-020 Latency: word pushed into empty FIFO at edge N SHALL appear on outd with out_valid[d] from cycle after edge N (one cycle).
REQ-021 Once asserted, out_valid[d] and outd SHALL stay stable until delivery or drop.
REQ-022 SHALL keep a wait counter, cleared on every pop, incremented each DRIVE cycle without delivery.
REQ-023 When TIMEOUT > 0 and the wait counter reaches TIMEOUT, SHALL pop head at that edge without delivery and increment drop_count.
REQ-024 drop_count SHALL saturate at 255 and never wrap.
REQ-025 out_ready bits of non-selected destinations SHALL be ignored.
REQ-026 Simultaneous push and pop with count 1 SHALL leave count 1, with new word becoming head next cycle.
REQ-027 FIFO pointers SHALL wrap modulo 2; order preserved strictly (no reordering across destinations).
REQ-028 busy SHALL equal (count != 0).

Reset
REQ-029 On rst_n low, SHALL immediately, independent of clk, clear FIFO count and pointers, wait counter, drop_count; state IDLE; out_valid 0, outk 0, in_ready 1 (after count clears), busy 0.
REQ-030 Words buffered when reset asserts mid-operation SHALL be discarded; no delivery after rst_n deasserts until a new push.
REQ-031 First push SHALL be accepted at the first rising edge with rst_n high.

Verification
REQ-032 Single word: push data 0xBEEF, dest 2, out_ready=4'b0100 -> next cycle out2=0xBEEF, out_valid=4'b0100, popped at that edge; out0/1/3 = 0.
REQ-033 Back-to-back: push 0x0001 dest0 then 0x0002 dest3, all ready -> out0=0x0001 one cycle, then out3=0x0002 next cycle, no gap; in_ready held 1.
REQ-034 Full: out_ready=0, push three words -> third refused (in_ready=0 after two pushes), busy=1, out_valid held stable on first word.
REQ-035 Timeout: TIMEOUT=15, dest1 never ready -> word dropped after 15 DRIVE cycles, drop_count=1, next word presented; 300 such drops -> drop_count=255.
REQ-036 Reset mid-operation: two words buffered, rst_n pulsed low between edges -> out_valid=0, busy=0, drop_count=0 immediately; after release, nothing delivered without a new push.
REQ-037 Wrong-ready: head dest 1, out_ready=4'b1101 -> no pop, out_valid=4'b0010 held until bit 1 asserts.
